// File: rtl/pc_redirect_if.sv
// Bundle between the EX stage / fetch and the PC redirect unit.
// The pipeline side is the master; pc_redirect itself attaches as the slave.
interface pc_redirect_if #(
    parameter int REG_WIDTH = 32
);
    logic                 pc_write;
    logic                 ex_valid;
    logic                 ex_is_branch;
    logic                 ex_is_jump;
    logic [2:0]           ex_funct3;
    logic                 br_eq;
    logic                 br_lt;
    logic [REG_WIDTH-1:0] ex_target;
    logic                 imem_ready;
    logic                 br_un;
    logic [REG_WIDTH-1:0] pc;
    logic [REG_WIDTH-1:0] pc_plus4;
    logic                 flush;
    logic                 redirect_pending;
    logic [31:0]          taken_cnt;

    modport master (
        output pc_write, ex_valid, ex_is_branch, ex_is_jump, ex_funct3,
               br_eq, br_lt, ex_target, imem_ready,
        input  br_un, pc, pc_plus4, flush, redirect_pending, taken_cnt
    );

    modport slave (
        input  pc_write, ex_valid, ex_is_branch, ex_is_jump, ex_funct3,
               br_eq, br_lt, ex_target, imem_ready,
        output br_un, pc, pc_plus4, flush, redirect_pending, taken_cnt
    );
endinterface

// File: rtl/pc_redirect.sv
// PC owner for the 5-stage pipeline: resolves EX branches/jumps into a redirect,
// and parks the redirect target when instruction memory is not ready.
module pc_redirect #(
    parameter int                   REG_WIDTH = 32,
    parameter logic [REG_WIDTH-1:0] RESET_PC  = '0
) (
    input logic         clk,
    input logic         rst_n,
    pc_redirect_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [REG_WIDTH-1:0] PC_STEP  = REG_WIDTH'(4);
    localparam logic [REG_WIDTH-1:0] BIT0_CLR = ~REG_WIDTH'(1);

    state_t               state;
    logic [REG_WIDTH-1:0] pc_q;
    logic [REG_WIDTH-1:0] pc_plus4_q;
    logic [REG_WIDTH-1:0] pend_q;
    logic [31:0]          taken_cnt_q;
    logic [REG_WIDTH-1:0] tgt;
    logic                 cond;
    logic                 taken;

    always_comb begin
        cond = 1'b0;
        case (bus.ex_funct3)
            3'b000:          cond = bus.br_eq;
            3'b001:          cond = ~bus.br_eq;
            3'b100, 3'b110:  cond = bus.br_lt;
            3'b101, 3'b111:  cond = ~bus.br_lt;
            default:         cond = 1'b0;
        endcase
    end

    // rst_n is folded in so no flush escapes while the pipeline is being reset.
    assign taken = rst_n & bus.ex_valid & bus.pc_write & (state == IDLE) &
                   (bus.ex_is_jump | (bus.ex_is_branch & cond));

    // JALR targets may be odd; only bit 0 is cleared, bit 1 passes through.
    assign tgt = bus.ex_target & BIT0_CLR;

    assign bus.br_un            = bus.ex_funct3[1];
    assign bus.flush            = taken;
    assign bus.pc               = pc_q;
    assign bus.pc_plus4         = pc_plus4_q;
    assign bus.redirect_pending = (state == HOLD);
    assign bus.taken_cnt        = taken_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_q        <= RESET_PC;
            pc_plus4_q  <= RESET_PC + PC_STEP;
            pend_q      <= '0;
            taken_cnt_q <= '0;
        end else begin
            if (taken && (taken_cnt_q != '1)) begin
                taken_cnt_q <= taken_cnt_q + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (taken) begin
                        if (bus.imem_ready) begin
                            pc_q       <= tgt;
                            pc_plus4_q <= tgt + PC_STEP;
                        end else begin
                            pend_q <= tgt;
                            state  <= HOLD;
                        end
                    end else if (bus.pc_write && bus.imem_ready) begin
                        pc_q       <= pc_plus4_q;
                        pc_plus4_q <= pc_plus4_q + PC_STEP;
                    end
                end
                // Wrong-path work is already flushed, so pc_write cannot block the parked redirect.
                HOLD: begin
                    if (bus.imem_ready) begin
                        pc_q       <= pend_q;
                        pc_plus4_q <= pend_q + PC_STEP;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
